avalon_harvard_bridge: RTL and testbench
========================================

# avalon_harvard_bridge

Parametrised Harvard-to-Avalon bridge between the MIPS core's separate instruction and data ports and a single Avalon-MM master port. Serialises each core step into an optional data access followed by an optional instruction fetch, then pulses `clk_enable` to advance the core one cycle. Generalises the first-generation controller with configurable address/data widths, explicit access sizes with byte-lane steering, misalignment detection, a waitrequest timeout and an optional one-entry instruction buffer.

## Interface
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: bus data width; 32 or 64. `BYTES = DATA_W/8`, `LW = log2(BYTES)`.
- `TIMEOUT`, 0: max consecutive waitrequest-high cycles per transfer; 0 disables the timeout.

Ports:
- `clk` in 1: clock; everything on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `av_address` out ADDR_W: word-aligned address, low LW bits always 0.
- `av_read`, `av_write` out 1: Avalon strobes.
- `av_waitrequest` in 1: slave stall.
- `av_writedata` out DATA_W; `av_byteenable` out BYTES; `av_readdata` in DATA_W.
- `active` in 1: core running; instruction fetch required.
- `clk_enable` out 1: core clock enable.
- `instr_address` in ADDR_W; `instr_readdata` out DATA_W.
- `data_address` in ADDR_W; `data_read`, `data_write` in 1.
- `data_size` in 2: 0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_W=64).
- `data_writedata` in DATA_W; `data_readdata` out DATA_W.
- `bus_error` out 1: sticky fault flag.

## Operation
- States: IDLE, DATA, INSTR, DONE, ERROR.
- Data request = `data_read ^ data_write`; both high counts as no request.
- IDLE: request → DATA if aligned, else ERROR. No request and `active` → INSTR, or DONE on buffer hit. Neither → stay; `clk_enable=1`.
- On IDLE exit, address, size, lane, writedata and direction are registered; `av_*` are driven from these registers and are stable for the whole transfer.
- Alignment: lane = `data_address[LW-1:0]`, `n = 1<<data_size`. Misaligned if lane mod n ≠ 0, or size 3 when DATA_W=32.
- Byteenable = `((1<<n)-1) << lane`. Writedata = `data_writedata << 8*lane`.
- DATA: strobe held until a rising edge with `av_waitrequest=0`. Read data = `(av_readdata >> 8*lane)`, zero-extended above n bytes, registered into `data_readdata`. Next state: INSTR if `active` (DONE on buffer hit), else DONE.
- INSTR: `av_read=1`, `av_address=instr_address` word-aligned, byteenable all ones. On `waitrequest=0`, register `av_readdata` into `instr_readdata` → DONE.
- DONE: `clk_enable=1` for exactly one cycle → IDLE.
- `clk_enable=0` in DATA, INSTR and ERROR, and in IDLE whenever a request or `active` is present.
- Timeout (TIMEOUT>0): counter clears on entering DATA/INSTR and counts waitrequest-high cycles. On reaching TIMEOUT, strobes drop next cycle → ERROR.
- ERROR: all strobes 0, `clk_enable=0`, `bus_error=1`. Exit only via reset.

## Timing
- Reset values: state IDLE, `av_read`/`av_write`/`av_address`/`av_writedata` 0, `av_byteenable` all ones, `instr_readdata` 0, `data_readdata` 0, `bus_error` 0, buffer invalid, `clk_enable` 0 while `reset` is high.
- Reset mid-transfer: strobes deassert asynchronously and the transfer is abandoned.
- Zero-wait data read plus fetch: cycle 0 IDLE, 1 DATA, 2 INSTR, 3 DONE (`clk_enable=1`), 4 IDLE. Each wait cycle adds one cycle.
- Fetch only: IDLE, INSTR, DONE → 3 cycles minimum.
- `data_readdata` and `instr_readdata` stay stable from capture until their next capture.
- Inputs are sampled only in IDLE. Changes during DATA/INSTR are ignored until the next IDLE.

## Configuration
- `HARVARD_BRIDGE_IBUF_EN` defined: one-entry instruction buffer (tag = word address, valid bit).
  - Hit in IDLE/DATA skips INSTR and reuses `instr_readdata`.
  - Filled on every INSTR completion.
  - Invalidated by any DATA write whose word address equals the tag.
- Undefined: every step with `active=1` performs INSTR; no buffer storage is synthesised.

## Test plan
- Reset, then `active=1`, `instr_address=0x100`, readdata `0x24020005`, waitrequest 0 → `av_read` at `0x100` in cycle 1, `instr_readdata=0x24020005`, `clk_enable` pulses in cycle 2 only.
- Byte write: `data_address=0x203`, size 0, writedata `0xAB`, DATA_W=32 → `av_address=0x200`, byteenable `1000`, `av_writedata=0xAB000000`, `av_write` held through 3 waitrequest cycles.
- Half read: `data_address=0x102`, size 1, readdata `0xBEEF1234` → `data_readdata=0x0000BEEF`. Half at `0x101` → `bus_error=1`, no strobe, `clk_enable` stays 0.
- TIMEOUT=4, waitrequest stuck high → `av_read` drops after 4 high cycles, ERROR entered, reset clears `bus_error`.
- With `HARVARD_BRIDGE_IBUF_EN`: two steps at the same `instr_address` → one INSTR transfer. Word write to that address in between → second step re-fetches.
- Assert reset during INSTR wait → `av_read=0` same cycle, outputs at reset values, fresh fetch after release.

Source files
------------

// File: rtl/avalon_harvard_bridge_if.sv
// rtl/avalon_harvard_bridge_if.sv - Avalon-MM master bus bundle for the Harvard bridge
interface avalon_harvard_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   av_address;
  logic                av_read;
  logic                av_write;
  logic                av_waitrequest;
  logic [DATA_W-1:0]   av_writedata;
  logic [DATA_W/8-1:0] av_byteenable;
  logic [DATA_W-1:0]   av_readdata;

  modport master (
    output av_address, av_read, av_write, av_writedata, av_byteenable,
    input  av_waitrequest, av_readdata
  );

  modport slave (
    input  av_address, av_read, av_write, av_writedata, av_byteenable,
    output av_waitrequest, av_readdata
  );
endinterface

// File: rtl/avalon_harvard_bridge.sv
// rtl/avalon_harvard_bridge.sv - serialises core data access + instruction fetch onto one Avalon-MM master
// Optional one-entry instruction buffer enabled by defining HARVARD_BRIDGE_IBUF_EN.
module avalon_harvard_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  avalon_harvard_bridge_if.master av,
  input  logic              active,
  output logic              clk_enable,
  input  logic [ADDR_W-1:0] instr_address,
  output logic [DATA_W-1:0] instr_readdata,
  input  logic [ADDR_W-1:0] data_address,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [1:0]        data_size,
  input  logic [DATA_W-1:0] data_writedata,
  output logic [DATA_W-1:0] data_readdata,
  output logic              bus_error
);
  localparam int BYTES = DATA_W / 8;
  localparam int LW    = $clog2(BYTES);
  localparam int WA_W  = ADDR_W - LW;
  localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [31:0] TO = 32'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_INSTR, S_DONE, S_ERROR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BYTES-1:0]  be_q, be_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              wr_q, wr_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic [WA_W-1:0]   iword_q, iword_d;
  logic              act_q, act_d;
  logic [DATA_W-1:0] drd_q, drd_d;
  logic [DATA_W-1:0] ird_q, ird_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              clk_en;

  logic              req, misaligned, timeout_hit, hit_idle, hit_data;
  logic [LW-1:0]     in_lane;
  logic [3:0]        in_n, q_n;
  logic [BYTES-1:0]  be_in;
  logic [DATA_W-1:0] wd_in, rd_shift, rd_ext;
  logic              unused_low;

  assign unused_low = ^instr_address[LW-1:0];

  assign req      = data_read ^ data_write;
  assign in_lane  = data_address[LW-1:0];
  assign in_n     = 4'd1 << data_size;
  assign q_n      = 4'd1 << size_q;
  assign misaligned = ((data_size == 2'd3) && (DATA_W == 32)) ||
                      ((({{(4-LW){1'b0}}, in_lane}) & (in_n - 4'd1)) != 4'd0);
  assign wd_in    = data_writedata << {in_lane, 3'b000};
  assign rd_shift = av.av_readdata >> {lane_q, 3'b000};
  // A stalled slave counts toward the timeout only while a strobe is up.
  assign timeout_hit = (TO != 32'd0) && av.av_waitrequest &&
                       (({{(32-CW){1'b0}}, cnt_q} + 32'd1) >= TO);

  always_comb begin
    be_in  = '0;
    rd_ext = '0;
    for (int i = 0; i < BYTES; i++) begin
      be_in[i] = (i >= int'(in_lane)) && (i < int'(in_lane) + int'(in_n));
      rd_ext[8*i +: 8] = (i < int'(q_n)) ? rd_shift[8*i +: 8] : 8'h00;
    end
  end

`ifdef HARVARD_BRIDGE_IBUF_EN
  logic            ibuf_valid_q, ibuf_valid_d;
  logic [WA_W-1:0] ibuf_tag_q, ibuf_tag_d;
  logic            ibuf_inval;

  // A write to the buffered word must win over a hit in the same step.
  assign ibuf_inval = wr_q && (addr_q[ADDR_W-1:LW] == ibuf_tag_q);
  assign hit_idle   = ibuf_valid_q && (ibuf_tag_q == instr_address[ADDR_W-1:LW]);
  assign hit_data   = ibuf_valid_q && !ibuf_inval && (ibuf_tag_q == iword_q);

  always_comb begin
    ibuf_valid_d = ibuf_valid_q;
    ibuf_tag_d   = ibuf_tag_q;
    if (state_q == S_DATA && !av.av_waitrequest && ibuf_inval) begin
      ibuf_valid_d = 1'b0;
    end
    if (state_q == S_INSTR && !av.av_waitrequest) begin
      ibuf_valid_d = 1'b1;
      ibuf_tag_d   = iword_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ibuf_valid_q <= 1'b0;
      ibuf_tag_q   <= '0;
    end else begin
      ibuf_valid_q <= ibuf_valid_d;
      ibuf_tag_q   <= ibuf_tag_d;
    end
  end
`else
  assign hit_idle = 1'b0;
  assign hit_data = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    wr_d    = wr_q;
    lane_d  = lane_q;
    size_d  = size_q;
    iword_d = iword_q;
    act_d   = act_q;
    drd_d   = drd_q;
    ird_d   = ird_q;
    cnt_d   = cnt_q;
    clk_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_en  = !(req || active);
        iword_d = instr_address[ADDR_W-1:LW];
        act_d   = active;
        if (req) begin
          if (misaligned) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
            addr_d  = {data_address[ADDR_W-1:LW], {LW{1'b0}}};
            be_d    = be_in;
            wd_d    = wd_in;
            wr_d    = data_write;
            lane_d  = in_lane;
            size_d  = data_size;
            cnt_d   = '0;
          end
        end else if (active) begin
          if (hit_idle) begin
            state_d = S_DONE;
          end else begin
            state_d = S_INSTR;
            addr_d  = {instr_address[ADDR_W-1:LW], {LW{1'b0}}};
            be_d    = '1;
            wr_d    = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (!av.av_waitrequest) begin
          if (!wr_q) begin
            drd_d = rd_ext;
          end
          if (act_q && !hit_data) begin
            state_d = S_INSTR;
            addr_d  = {iword_q, {LW{1'b0}}};
            be_d    = '1;
            wr_d    = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
          end
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_INSTR: begin
        if (!av.av_waitrequest) begin
          ird_d   = av.av_readdata;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        clk_en  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      be_q    <= '1;
      wd_q    <= '0;
      wr_q    <= 1'b0;
      lane_q  <= '0;
      size_q  <= '0;
      iword_q <= '0;
      act_q   <= 1'b0;
      drd_q   <= '0;
      ird_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      wr_q    <= wr_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      iword_q <= iword_d;
      act_q   <= act_d;
      drd_q   <= drd_d;
      ird_q   <= ird_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode straight from the state register so reset drops them at once.
  assign av.av_read       = ((state_q == S_DATA) && !wr_q) || (state_q == S_INSTR);
  assign av.av_write      = (state_q == S_DATA) && wr_q;
  assign av.av_address    = addr_q;
  assign av.av_byteenable = be_q;
  assign av.av_writedata  = wd_q;
  assign instr_readdata   = ird_q;
  assign data_readdata    = drd_q;
  assign bus_error        = (state_q == S_ERROR);
  assign clk_enable       = clk_en && !reset;
endmodule

// File: tb/tb_avalon_harvard_bridge.sv
// tb/tb_avalon_harvard_bridge.sv - randomized step-level model bench for avalon_harvard_bridge
module tb_avalon_harvard_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic        active;
  logic        clk_enable;
  logic [31:0] instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;
  logic        data_read, data_write, bus_error;
  logic [1:0]  data_size;

  always #5 clk = ~clk;

  avalon_harvard_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  avalon_harvard_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .av(bus), .active(active), .clk_enable(clk_enable),
    .instr_address(instr_address), .instr_readdata(instr_readdata),
    .data_address(data_address), .data_read(data_read), .data_write(data_write),
    .data_size(data_size), .data_writedata(data_writedata),
    .data_readdata(data_readdata), .bus_error(bus_error)
  );

`ifdef HARVARD_BRIDGE_IBUF_EN
  localparam bit IBUF = 1'b1;
`else
  localparam bit IBUF = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a & ~32'h3) * 32'h9E3779B1) ^ 32'hC3A55A3C;
  endfunction

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } xfer_t;

  xfer_t       expq[$];
  logic        force_en = 1'b0;
  logic [31:0] force_val = '0;
  int          fixed_waits = 0;
  logic        stuck = 1'b0;
  int          waits_total = 0;
  int          xfer_count = 0;
  logic        pending = 1'b0;
  int          wl = 0;
  logic [31:0] last_addr, last_wd;
  logic [3:0]  last_be;
  int          last_k;

  logic [31:0] exp_data, exp_instr;
  logic        m_valid;
  logic [29:0] m_tag;

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return force_en ? force_val : mem_word(a);
  endfunction

  // Slave responder and transfer checker: every strobe cycle must match the expected head.
  always @(negedge clk) begin
    if (reset) begin
      pending = 1'b0;
      bus.av_waitrequest = 1'b0;
    end else if (bus.av_read || bus.av_write) begin
      if (expq.size() == 0) begin
        failures++;
        checks++;
        $display("FAIL unexpected_xfer actual=%h required=none", bus.av_address);
      end else begin
        check("xfer_addr", bus.av_address, expq[0].addr);
        check("xfer_write", bus.av_write, expq[0].wr);
        check("xfer_read", bus.av_read, !expq[0].wr);
        check("xfer_be", bus.av_byteenable, expq[0].be);
        if (expq[0].wr) check("xfer_wdata", bus.av_writedata, expq[0].wd);
      end
      if (!pending) wl = stuck ? 1000000 : (fixed_waits >= 0 ? fixed_waits : int'($urandom_range(0, 2)));
      if (wl > 0) begin
        wl--;
        waits_total++;
        pending = 1'b1;
        bus.av_waitrequest = 1'b1;
        bus.av_readdata = $urandom;
      end else begin
        pending = 1'b0;
        bus.av_waitrequest = 1'b0;
        bus.av_readdata = src_word(bus.av_address);
        last_addr = bus.av_address;
        last_be = bus.av_byteenable;
        last_wd = bus.av_writedata;
        xfer_count++;
        if (expq.size() != 0) void'(expq.pop_front());
      end
    end else begin
      pending = 1'b0;
      bus.av_waitrequest = 1'($urandom);
      bus.av_readdata = $urandom;
    end
  end

  task automatic idle_inputs();
    active = 1'b0;
    data_read = 1'b0;
    data_write = 1'b0;
  endtask

  task automatic model_reset();
    exp_data = '0;
    exp_instr = '0;
    m_valid = 1'b0;
    m_tag = '0;
    expq.delete();
    stuck = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_bus_error", bus_error, 0);
    check("rst_clk_enable", clk_enable, 0);
    check("rst_av_read", bus.av_read, 0);
    check("rst_av_write", bus.av_write, 0);
    check("rst_av_address", bus.av_address, 0);
    check("rst_av_be", bus.av_byteenable, 4'hF);
    check("rst_av_wdata", bus.av_writedata, 0);
    check("rst_instr_rd", instr_readdata, 0);
    check("rst_data_rd", data_readdata, 0);
    reset = 1'b0;
    model_reset();
  endtask

  // One core step: model computes the transfers, latency and captured data from the rules.
  task automatic step(input logic rd, input logic wr, input logic [1:0] sz, input logic [31:0] da,
                      input logic [31:0] dwd, input logic [31:0] ia, input logic act);
    logic        req;
    int          exp_k, k, lane, n;
    logic [63:0] mask;
    xfer_t       x;
    @(negedge clk);
    data_read = rd; data_write = wr; data_size = sz; data_address = da;
    data_writedata = dwd; instr_address = ia; active = act;
    waits_total = 0;
    req = rd ^ wr;
    exp_k = 1;
    if (!req && !act) begin
      #1 check("idle_clk_enable", clk_enable, 1);
      @(negedge clk);
      check("idle_clk_enable_hold", clk_enable, 1);
      return;
    end
    if (req) begin
      lane = int'(da[1:0]);
      n = 1 << sz;
      mask = (64'd1 << (8 * n)) - 64'd1;
      x.wr = wr;
      x.addr = da & ~32'h3;
      x.wd = dwd << (8 * lane);
      x.be = 4'(((1 << n) - 1) << lane);
      expq.push_back(x);
      exp_k++;
      if (rd) exp_data = 32'((64'(src_word(da)) >> (8 * lane)) & mask);
      if (wr && m_tag == da[31:2]) m_valid = 1'b0;
    end
    if (act) begin
      if (!(IBUF && m_valid && m_tag == ia[31:2])) begin
        x.wr = 1'b0;
        x.addr = ia & ~32'h3;
        x.wd = '0;
        x.be = 4'hF;
        expq.push_back(x);
        exp_k++;
        exp_instr = src_word(ia);
        m_tag = ia[31:2];
        m_valid = 1'b1;
      end
    end
    #1 check("busy_clk_enable", clk_enable, 0);
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (clk_enable) break;
      if (k > 40) begin
        failures++;
        checks++;
        $display("FAIL step_timeout actual=%0d required=%0d", k, exp_k);
        break;
      end
      data_read = 1'($urandom); data_write = 1'($urandom); data_size = 2'($urandom);
      data_address = $urandom; data_writedata = $urandom; instr_address = $urandom;
      active = 1'($urandom);
    end
    idle_inputs();
    last_k = k;
    check("step_latency", k, exp_k + waits_total);
    check("data_readdata", data_readdata, exp_data);
    check("instr_readdata", instr_readdata, exp_instr);
    check("xfers_left", expq.size(), 0);
    check("step_bus_error", bus_error, 0);
    expq.delete();
  endtask

  task automatic err_step(input logic [1:0] sz, input logic [31:0] da);
    @(negedge clk);
    data_read = 1'b1; data_write = 1'b0; data_size = sz; data_address = da; active = 1'b1;
    #1 check("err_clk_enable0", clk_enable, 0);
    repeat (4) begin
      @(negedge clk);
      check("err_clk_enable", clk_enable, 0);
      check("err_strobe", bus.av_read | bus.av_write, 0);
    end
    check("err_bus_error", bus_error, 1);
    do_reset();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n0;
    logic [31:0] ibase[5];
    reset = 1'b1;
    idle_inputs();
    data_size = '0; data_address = '0; data_writedata = '0; instr_address = '0;
    model_reset();
    ibase[0] = 32'h100; ibase[1] = 32'h104; ibase[2] = 32'h200; ibase[3] = 32'h204; ibase[4] = 32'h208;
    do_reset();

    // Fetch at 0x100
    fixed_waits = 0; force_en = 1'b1; force_val = 32'h24020005;
    step(0, 0, 0, 0, 0, 32'h100, 1);
    check("fetch_lat_lit", last_k, 2);
    check("fetch_addr_lit", last_addr, 32'h100);
    check("fetch_data_lit", instr_readdata, 32'h24020005);

    // Byte write with 3 wait cycles
    fixed_waits = 3;
    step(0, 1, 0, 32'h203, 32'hAB, 0, 0);
    check("bw_addr_lit", last_addr, 32'h200);
    check("bw_be_lit", last_be, 4'b1000);
    check("bw_wd_lit", last_wd, 32'hAB000000);
    check("bw_lat_lit", last_k, 5);

    // Half read
    fixed_waits = 0; force_val = 32'hBEEF1234;
    step(1, 0, 1, 32'h102, 0, 0, 0);
    check("hr_data_lit", data_readdata, 32'h0000BEEF);
    force_en = 1'b0;

    // Repeat fetch, write to fetched word, fetch again
    n0 = xfer_count;
    step(0, 0, 0, 0, 0, 32'h300, 1);
    step(0, 0, 0, 0, 0, 32'h300, 1);
`ifdef HARVARD_BRIDGE_IBUF_EN
    check("ibuf_hit_xfers", xfer_count - n0, 1);
`else
    check("nobuf_xfers", xfer_count - n0, 2);
`endif
    step(0, 1, 2, 32'h300, 32'h11223344, 0, 0);
    step(0, 0, 0, 0, 0, 32'h300, 1);
`ifdef HARVARD_BRIDGE_IBUF_EN
    check("ibuf_refetch_xfers", xfer_count - n0, 3);
`else
    check("nobuf_refetch_xfers", xfer_count - n0, 4);
`endif

    // Misaligned and illegal size
    err_step(2'd1, 32'h101);
    err_step(2'd3, 32'h200);

    // Timeout with waitrequest stuck
    stuck = 1'b1;
    @(negedge clk);
    active = 1'b1; instr_address = 32'h180;
    xfer_count = xfer_count;
    begin
      xfer_t x;
      x.wr = 1'b0; x.addr = 32'h180; x.wd = '0; x.be = 4'hF;
      expq.push_back(x);
    end
    c = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.av_read) c++;
    end
    check("timeout_read_cycles", c, 4);
    check("timeout_bus_error", bus_error, 1);
    check("timeout_clk_enable", clk_enable, 0);
    do_reset();

    // Fill outputs, then reset during a stalled fetch
    fixed_waits = 0;
    step(1, 0, 2, 32'h204, 0, 32'h104, 1);
    stuck = 1'b1;
    @(negedge clk);
    active = 1'b1; instr_address = 32'h208;
    begin
      xfer_t x;
      x.wr = 1'b0; x.addr = 32'h208; x.wd = '0; x.be = 4'hF;
      expq.push_back(x);
    end
    repeat (2) @(negedge clk);
    check("mid_read_before", bus.av_read, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_av_read", bus.av_read, 0);
    check("mid_rst_instr_rd", instr_readdata, 0);
    check("mid_rst_data_rd", data_readdata, 0);
    check("mid_rst_av_address", bus.av_address, 0);
    check("mid_rst_clk_enable", clk_enable, 0);
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(0, 0, 0, 0, 0, 32'h208, 1);

    // Randomized steps
    fixed_waits = -1;
    for (int i = 0; i < 80; i++) begin
      int op;
      logic [1:0] sz;
      logic [31:0] da, ia;
      op = int'($urandom_range(0, 3));
      sz = 2'($urandom_range(0, 2));
      da = 32'h200 + ($urandom_range(0, 7) << 2) + ($urandom_range(0, 3) & ~((32'd1 << sz) - 1));
      ia = ibase[$urandom_range(0, 4)] + 32'($urandom_range(0, 3));
      step(op == 1 || op == 3, op == 2 || op == 3, sz, da, $urandom, ia, ($urandom_range(0, 4) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
